// File: rtl/tri_raster_pkg.sv
// Shared types and width helpers for the tri_raster scanline rasteriser.
// Vertex struct fields are sized for the widest legal grid; narrower builds zero-extend.
package tri_raster_pkg;

  localparam int COORD_W_MAX = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD1,
    ST_LOAD2,
    ST_SETUP,
    ST_SCAN,
    ST_DONE
  } tri_state_t;

  typedef struct packed {
    logic [COORD_W_MAX-1:0] x;
    logic [COORD_W_MAX-1:0] y;
  } tri_vtx_t;

  function automatic int dlt_w(input int cw);
    return cw + 1;
  endfunction

  function automatic int edge_w(input int cw);
    return 2 * cw + 3;
  endfunction

  function automatic logic [COORD_W_MAX-1:0] min3(input logic [COORD_W_MAX-1:0] a,
                                                  input logic [COORD_W_MAX-1:0] b,
                                                  input logic [COORD_W_MAX-1:0] c);
    logic [COORD_W_MAX-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [COORD_W_MAX-1:0] max3(input logic [COORD_W_MAX-1:0] a,
                                                  input logic [COORD_W_MAX-1:0] b,
                                                  input logic [COORD_W_MAX-1:0] c);
    logic [COORD_W_MAX-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tri_raster_edge_eval.sv
// tri_edge_eval: combinational three-edge function for one candidate pixel; zero latency.
// Inside when no edge disagrees in sign, so either winding and boundary pixels pass.
module tri_edge_eval
  import tri_raster_pkg::*;
#(
  parameter int COORD_W = 3
) (
  input  logic [COORD_W-1:0]      i_x,
  input  logic [COORD_W-1:0]      i_y,
  input  logic [2:0][COORD_W-1:0] i_xa,
  input  logic [2:0][COORD_W-1:0] i_ya,
  input  logic [2:0][COORD_W:0]   i_dx,
  input  logic [2:0][COORD_W:0]   i_dy,
  output logic                    o_inside
);

  localparam int DW = dlt_w(COORD_W);
  localparam int EW = edge_w(COORD_W);

  logic signed [DW-1:0] w_ox [3];
  logic signed [DW-1:0] w_oy [3];
  logic signed [EW-1:0] w_e  [3];
  logic                 w_nonneg;
  logic                 w_nonpos;

  always_comb begin
    w_nonneg = 1'b1;
    w_nonpos = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w_ox[k] = $signed({1'b0, i_x}) - $signed({1'b0, i_xa[k]});
      w_oy[k] = $signed({1'b0, i_y}) - $signed({1'b0, i_ya[k]});
      // Operands widened first so the products cannot wrap.
      w_e[k]  = EW'(w_ox[k]) * EW'($signed(i_dy[k])) - EW'(w_oy[k]) * EW'($signed(i_dx[k]));
      if (w_e[k][EW-1]) begin
        w_nonneg = 1'b0;
      end
      if (!w_e[k][EW-1] && (w_e[k] != '0)) begin
        w_nonpos = 1'b0;
      end
    end
  end

  assign o_inside = w_nonneg | w_nonpos;

endmodule

// File: rtl/tri_raster.sv
// tri_raster: scanline triangle rasteriser, first pixel 5 cycles after nt, one candidate/cycle.
// Define TRI_RASTER_OUT_READY_EN for out_rdy backpressure (holds pixel, freezes cursor).
module tri_raster
  import tri_raster_pkg::*;
#(
  parameter int COORD_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
`ifdef TRI_RASTER_OUT_READY_EN
  input  logic               out_rdy,
`endif
  input  logic               nt,
  input  logic [COORD_W-1:0] xi,
  input  logic [COORD_W-1:0] yi,
  output logic               busy,
  output logic               po,
  output logic [COORD_W-1:0] xo,
  output logic [COORD_W-1:0] yo
);

  localparam int DW = dlt_w(COORD_W);
  localparam int MW = COORD_W_MAX;

  tri_state_t          r_state;
  tri_state_t          w_state_nxt;
  tri_vtx_t            r_v0;
  tri_vtx_t            r_v1;
  tri_vtx_t            r_v2;
  tri_vtx_t            w_vin;
  logic [MW-1:0]       r_xmin;
  logic [MW-1:0]       r_xmax;
  logic [MW-1:0]       r_ymax;
  logic [MW-1:0]       r_cx;
  logic [MW-1:0]       r_cy;
  logic [MW-1:0]       w_xmin;
  logic [MW-1:0]       w_ymin;
  logic [2:0][DW-1:0]  r_dx;
  logic [2:0][DW-1:0]  r_dy;
  logic [2:0][DW-1:0]  w_dx;
  logic [2:0][DW-1:0]  w_dy;
  logic [2:0][COORD_W-1:0] w_xa;
  logic [2:0][COORD_W-1:0] w_ya;
  logic                r_po;
  logic [COORD_W-1:0]  r_xo;
  logic [COORD_W-1:0]  r_yo;
  logic                w_adv;
  logic                w_last;
  logic                w_inside;

`ifdef TRI_RASTER_OUT_READY_EN
  assign w_adv = !r_po || out_rdy;
`else
  assign w_adv = 1'b1;
`endif

  assign w_vin  = '{x: MW'(xi), y: MW'(yi)};
  assign w_last = (r_cx == r_xmax) && (r_cy == r_ymax);
  assign w_xmin = min3(r_v0.x, r_v1.x, r_v2.x);
  assign w_ymin = min3(r_v0.y, r_v1.y, r_v2.y);

  assign w_xa[0] = r_v0.x[COORD_W-1:0];
  assign w_xa[1] = r_v1.x[COORD_W-1:0];
  assign w_xa[2] = r_v2.x[COORD_W-1:0];
  assign w_ya[0] = r_v0.y[COORD_W-1:0];
  assign w_ya[1] = r_v1.y[COORD_W-1:0];
  assign w_ya[2] = r_v2.y[COORD_W-1:0];

  // Edge k runs from vertex k to vertex k+1 (mod 3).
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_dx[k] = $signed({1'b0, w_xa[(k+1)%3]}) - $signed({1'b0, w_xa[k]});
      w_dy[k] = $signed({1'b0, w_ya[(k+1)%3]}) - $signed({1'b0, w_ya[k]});
    end
  end

  tri_edge_eval #(
    .COORD_W (COORD_W)
  ) u_edge (
    .i_x      (r_cx[COORD_W-1:0]),
    .i_y      (r_cy[COORD_W-1:0]),
    .i_xa     (w_xa),
    .i_ya     (w_ya),
    .i_dx     (r_dx),
    .i_dy     (r_dy),
    .o_inside (w_inside)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (nt) w_state_nxt = ST_LOAD1;
      ST_LOAD1: w_state_nxt = ST_LOAD2;
      ST_LOAD2: w_state_nxt = ST_SETUP;
      ST_SETUP: w_state_nxt = ST_SCAN;
      ST_SCAN:  if (w_adv && w_last) w_state_nxt = ST_DONE;
      ST_DONE:  if (w_adv) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v0   <= '0;
      r_v1   <= '0;
      r_v2   <= '0;
      r_xmin <= '0;
      r_xmax <= '0;
      r_ymax <= '0;
      r_cx   <= '0;
      r_cy   <= '0;
      r_dx   <= '0;
      r_dy   <= '0;
      r_po   <= 1'b0;
      r_xo   <= '0;
      r_yo   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (nt) r_v0 <= w_vin;
        end
        ST_LOAD1: r_v1 <= w_vin;
        ST_LOAD2: r_v2 <= w_vin;
        ST_SETUP: begin
          r_xmin <= w_xmin;
          r_xmax <= max3(r_v0.x, r_v1.x, r_v2.x);
          r_ymax <= max3(r_v0.y, r_v1.y, r_v2.y);
          r_cx   <= w_xmin;
          r_cy   <= w_ymin;
          r_dx   <= w_dx;
          r_dy   <= w_dy;
        end
        ST_SCAN: begin
          if (w_adv) begin
            r_po <= w_inside;
            if (w_inside) begin
              r_xo <= r_cx[COORD_W-1:0];
              r_yo <= r_cy[COORD_W-1:0];
            end
            if (r_cx == r_xmax) begin
              r_cx <= r_xmin;
              r_cy <= r_cy + 1'b1;
            end else begin
              r_cx <= r_cx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (w_adv) r_po <= 1'b0;
        end
        default: r_po <= 1'b0;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign po   = r_po;
  assign xo   = r_xo;
  assign yo   = r_yo;

endmodule

// File: tb/tb_tri_raster.sv
// Randomised scoreboard bench for tri_raster: an area-sum reference model queues expected
// pixels, a negedge monitor pops and compares, and the driver checks busy/po timing.
module tb_tri_raster;

  localparam int W = 4;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b1;
  logic         nt      = 1'b0;
  logic [W-1:0] xi      = '0;
  logic [W-1:0] yi      = '0;
  logic         busy;
  logic         po;
  logic [W-1:0] xo;
  logic [W-1:0] yo;
`ifdef TRI_RASTER_OUT_READY_EN
  logic         out_rdy = 1'b1;
`endif

  int n_vec      = 0;
  int n_err      = 0;
  int cyc        = 0;
  int t_nt       = 0;
  int first_po   = -1;
  int stall_left = 0;
  int last_x     = 0;
  int last_y     = 0;
  int exp_q[$];

  tri_raster #(.COORD_W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef TRI_RASTER_OUT_READY_EN
    .out_rdy (out_rdy),
`endif
    .nt      (nt),
    .xi      (xi),
    .yi      (yi),
    .busy    (busy),
    .po      (po),
    .xo      (xo),
    .yo      (yo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int area2(input int px, input int py, input int qx, input int qy,
                               input int rx, input int ry);
    int v;
    v = (qx - px) * (ry - py) - (qy - py) * (rx - px);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int imin3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic int imax3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // A lattice point is covered when the three sub-triangles it forms exactly tile the triangle.
  task automatic model(input int ax, input int ay, input int bx, input int by,
                       input int cx, input int cy, output int n, output int first_idx);
    int tot;
    int idx;
    tot       = area2(ax, ay, bx, by, cx, cy);
    idx       = 0;
    first_idx = -1;
    for (int y = imin3(ay, by, cy); y <= imax3(ay, by, cy); y++) begin
      for (int x = imin3(ax, bx, cx); x <= imax3(ax, bx, cx); x++) begin
        if (area2(x, y, ax, ay, bx, by) + area2(x, y, bx, by, cx, cy) +
            area2(x, y, cx, cy, ax, ay) == tot) begin
          exp_q.push_back(x * 256 + y);
          if (first_idx < 0) first_idx = idx;
        end
        idx++;
      end
    end
    n = idx;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (po) begin
        if (first_po < 0) first_po = cyc - t_nt;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_pixel: got (%0d,%0d), expected no pixel", xo, yo);
        end else begin
          check("pix_x", int'(xo), exp_q[0] / 256);
          check("pix_y", int'(yo), exp_q[0] % 256);
          if (stall_left > 0) begin
            stall_left--;
`ifdef TRI_RASTER_OUT_READY_EN
            out_rdy = 1'b0;
`endif
          end else begin
`ifdef TRI_RASTER_OUT_READY_EN
            out_rdy = 1'b1;
`endif
            void'(exp_q.pop_front());
            last_x = int'(xo);
            last_y = int'(yo);
          end
        end
      end else begin
        check("hold_x", int'(xo), last_x);
        check("hold_y", int'(yo), last_y);
      end
    end
  end

  task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int stall, input int abort_at);
    int n;
    int first_idx;
    int k;
    bit aborted;
    model(ax, ay, bx, by, cx, cy, n, first_idx);
    first_po   = -1;
    stall_left = stall;
    aborted    = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    nt   = 1'b1;
    xi   = W'(ax);
    yi   = W'(ay);
    t_nt = cyc;
    @(negedge clk);
    check("busy_rise", int'(busy), 1);
    nt = 1'($urandom_range(0, 1));
    xi = W'(bx);
    yi = W'(by);
    @(negedge clk);
    nt = 1'($urandom_range(0, 1));
    xi = W'(cx);
    yi = W'(cy);
    k  = 0;
    while (busy && k < 4000 && !aborted) begin
      @(negedge clk);
      k++;
      nt = 1'($urandom_range(0, 1));
      xi = W'($urandom_range(0, (1 << W) - 1));
      yi = W'($urandom_range(0, (1 << W) - 1));
      if (abort_at > 0 && k == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_po", int'(po), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_xo", int'(xo), 0);
        check("rst_yo", int'(yo), 0);
        exp_q.delete();
        last_x     = 0;
        last_y     = 0;
        stall_left = 0;
        aborted    = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    nt = 1'b0;
    if (!aborted) begin
      check("busy_fall_cycle", cyc - t_nt, 5 + n + stall);
      check("first_po_cycle", first_po, 5 + first_idx);
      check("leftover_pixels", exp_q.size(), 0);
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_po", int'(po), 0);
    check("reset_xo", int'(xo), 0);
    check("reset_yo", int'(yo), 0);
    reset_n = 1'b1;

    run_tri(0, 0, 4, 0, 0, 4, 0, 0);
    run_tri(0, 0, 0, 4, 4, 0, 0, 0);
    run_tri(1, 1, 3, 3, 2, 2, 0, 0);
    run_tri(5, 5, 5, 5, 5, 5, 0, 0);
    run_tri(15, 0, 15, 15, 0, 15, 0, 0);
    run_tri(15, 0, 15, 15, 0, 15, 0, 40);
    run_tri(2, 7, 9, 1, 12, 13, 0, 0);
    run_tri(0, 15, 15, 0, 7, 7, 0, 0);
`ifdef TRI_RASTER_OUT_READY_EN
    run_tri(0, 0, 4, 0, 0, 4, 3, 0);
`endif
    for (int i = 0; i < 40; i++) begin
      run_tri($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
